// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front end: kernel size, default image size
// and the patch scanner state encoding.
package cnn_pkg;

  localparam int unsigned K         = 3;
  localparam int unsigned IMG_W_DEF = 28;
  localparam int unsigned IMG_H_DEF = 28;
  localparam int unsigned COORD_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_VALID,
    ST_DONE
  } scan_state_e;

  // Offset of window element k (row-major) from the window's top-left pixel.
  function automatic int unsigned win_offset(input int unsigned k, input int unsigned img_w);
    return (k / K) * img_w + (k % K);
  endfunction

endpackage

// File: rtl/patch_scan_ctrl.sv
// Raster-scans a 3x3 window over the image, driving nine registered memory
// addresses and a load/valid/ready handshake toward the patch latch.
module patch_scan_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               patch_ready,
  output logic [ADDR_W-1:0]  pixel_addr0,
  output logic [ADDR_W-1:0]  pixel_addr1,
  output logic [ADDR_W-1:0]  pixel_addr2,
  output logic [ADDR_W-1:0]  pixel_addr3,
  output logic [ADDR_W-1:0]  pixel_addr4,
  output logic [ADDR_W-1:0]  pixel_addr5,
  output logic [ADDR_W-1:0]  pixel_addr6,
  output logic [ADDR_W-1:0]  pixel_addr7,
  output logic [ADDR_W-1:0]  pixel_addr8,
  output logic               load,
  output logic               patch_valid,
  output logic [COORD_W-1:0] patch_row,
  output logic [COORD_W-1:0] patch_col,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - K);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - K);

  scan_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0]  addr_q [K*K];
  logic [ADDR_W-1:0]  addr_d [K*K];
  logic               win_upd;
  logic               last_patch;

  assign last_patch = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    row_d   = row_q;
    col_d   = col_q;
    win_upd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          base_d  = '0;
          row_d   = '0;
          col_d   = '0;
          win_upd = 1'b1;
        end
      end
      ST_ADDR:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_VALID;
      ST_VALID: begin
        if (patch_ready) begin
          if (last_patch) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
            win_upd = 1'b1;
            if (col_q < COL_LAST) begin
              col_d  = col_q + 1'b1;
              base_d = base_q + 1'b1;
            end else begin
              col_d  = '0;
              row_d  = row_q + 1'b1;
              base_d = base_q + ADDR_W'(K);
            end
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort overrides every transition above, including acceptance and DONE.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      base_d  = base_q;
      row_d   = row_q;
      col_d   = col_q;
      win_upd = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < K*K; k++) begin
      addr_d[k] = base_d + ADDR_W'(win_offset(k, IMG_W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (win_upd) begin
        addr_q <= addr_d;
      end
    end
  end

  assign pixel_addr0 = addr_q[0];
  assign pixel_addr1 = addr_q[1];
  assign pixel_addr2 = addr_q[2];
  assign pixel_addr3 = addr_q[3];
  assign pixel_addr4 = addr_q[4];
  assign pixel_addr5 = addr_q[5];
  assign pixel_addr6 = addr_q[6];
  assign pixel_addr7 = addr_q[7];
  assign pixel_addr8 = addr_q[8];

  assign patch_row   = row_q;
  assign patch_col   = col_q;
  assign load        = (state_q == ST_LOAD);
  assign patch_valid = (state_q == ST_VALID);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_patch_scan_ctrl.sv
// Directed/randomized bench for patch_scan_ctrl; expected windows come from
// patch index arithmetic over the image grid.
module tb_patch_scan_ctrl;

  localparam int unsigned W    = 28;
  localparam int unsigned H    = 28;
  localparam int unsigned AW   = 10;
  localparam int unsigned NCOL = W - 2;
  localparam int unsigned NP   = NCOL * (H - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          patch_ready = 1'b0;
  logic [AW-1:0] pa0, pa1, pa2, pa3, pa4, pa5, pa6, pa7, pa8;
  logic          load, patch_valid, busy, done;
  logic [4:0]    patch_row, patch_col;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned hs = 0;
  int unsigned done_seen = 0;
  int unsigned hs0, d0;

  always #5 clk = ~clk;

  patch_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .patch_ready(patch_ready),
    .pixel_addr0(pa0), .pixel_addr1(pa1), .pixel_addr2(pa2),
    .pixel_addr3(pa3), .pixel_addr4(pa4), .pixel_addr5(pa5),
    .pixel_addr6(pa6), .pixel_addr7(pa7), .pixel_addr8(pa8),
    .load(load), .patch_valid(patch_valid),
    .patch_row(patch_row), .patch_col(patch_col),
    .busy(busy), .done(done)
  );

  // Handshake and done monitor, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (rst && patch_valid && patch_ready && !abort) hs++;
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_pa(input int unsigned k);
    case (k)
      0: return 32'(pa0);
      1: return 32'(pa1);
      2: return 32'(pa2);
      3: return 32'(pa3);
      4: return 32'(pa4);
      5: return 32'(pa5);
      6: return 32'(pa6);
      7: return 32'(pa7);
      default: return 32'(pa8);
    endcase
  endfunction

  // Address of window element k for the p-th patch in raster order.
  function automatic logic [31:0] exp_addr(input int unsigned p, input int unsigned k);
    int unsigned r = p / NCOL;
    int unsigned c = p % NCOL;
    return (r + k / 3) * W + c + k % 3;
  endfunction

  task automatic chk_patch(input int unsigned p);
    chk("patch_row", 32'(patch_row), p / NCOL);
    chk("patch_col", 32'(patch_col), p % NCOL);
    for (int unsigned k = 0; k < 9; k++)
      chk($sformatf("pixel_addr%0d_p%0d", k, p), get_pa(k), exp_addr(p, k));
  endtask

  task automatic chk_all_zero(input string tag);
    for (int unsigned k = 0; k < 9; k++) chk($sformatf("%s_addr%0d", tag, k), get_pa(k), 0);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_valid"}, 32'(patch_valid), 0);
    chk({tag, "_row"}, 32'(patch_row), 0);
    chk({tag, "_col"}, 32'(patch_col), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Called at the negedge before the edge that samples start or accepts a patch.
  task automatic expect_patch(input int unsigned p, input bit rnd);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (patch_valid !== 1'b1) begin
        chk("busy_in_flight", 32'(busy), 1);
        chk("load_timing", 32'(load), (n == 2) ? 1 : 0);
        chk("addr0_early", get_pa(0), exp_addr(p, 0));
        chk("addr8_early", get_pa(8), exp_addr(p, 8));
        if (rnd) patch_ready = 1'($urandom_range(0, 1));
      end
    end while (patch_valid !== 1'b1 && n < 12);
    chk("latency", n, 3);
    chk("patch_valid", 32'(patch_valid), 1);
    chk("load_in_valid", 32'(load), 0);
    chk_patch(p);
  endtask

  task automatic accept(input int unsigned p, input int unsigned hold);
    patch_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("bp_valid", 32'(patch_valid), 1);
      chk("bp_load", 32'(load), 0);
      chk_patch(p);
    end
    patch_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy), 0);

    // Scan 1: patch_ready tied high, full image
    hs0 = hs; d0 = done_seen;
    patch_ready = 1'b1;
    start = 1'b1;
    for (int unsigned p = 0; p < NP; p++) begin
      expect_patch(p, 1'b0);
      if (p == 0) begin
        chk("first_addr3", get_pa(3), 28);
        chk("first_addr8", get_pa(8), 58);
      end
    end
    chk("last_row", 32'(patch_row), 25);
    chk("last_col", 32'(patch_col), 25);
    chk("last_addr8", get_pa(8), 783);
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_valid", 32'(patch_valid), 0);
    patch_ready = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("scan1_handshakes", hs - hs0, NP);
    chk("scan1_done_count", done_seen - d0, 1);

    // Scan 2: backpressure, ignored start, abort during LOAD of patch 5
    d0 = done_seen;
    start = 1'b1;
    expect_patch(0, 1'b1);
    start = 1'b1;
    accept(0, 10);
    start = 1'b0;
    for (int unsigned p = 1; p < 5; p++) begin
      expect_patch(p, 1'b1);
      accept(p, $urandom_range(0, 3));
    end
    @(negedge clk);
    chk("p5_addr_state_load", 32'(load), 0);
    chk("p5_addr0", get_pa(0), exp_addr(5, 0));
    @(negedge clk);
    chk("p5_load", 32'(load), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    patch_ready = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_valid", 32'(patch_valid), 0);
    @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 0);
    chk("abort_no_done", done_seen - d0, 0);

    // Scan 3: restart at (0,0), row wrap, reset while VALID
    start = 1'b1;
    expect_patch(0, 1'b1);
    for (int unsigned p = 0; p < 40; p++) begin
      accept(p, $urandom_range(0, 2));
      expect_patch(p + 1, 1'b1);
      if (p + 1 == 26) begin
        chk("wrap_row", 32'(patch_row), 1);
        chk("wrap_col", 32'(patch_col), 0);
        chk("wrap_addr0", get_pa(0), 28);
        chk("wrap_addr8", get_pa(8), 86);
      end
    end
    patch_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_valid", 32'(patch_valid), 0);

    // Scan 4: random backpressure, full image to done
    hs0 = hs; d0 = done_seen;
    start = 1'b1;
    expect_patch(0, 1'b1);
    for (int unsigned p = 0; p < NP; p++) begin
      accept(p, $urandom_range(0, 2));
      if (p < NP - 1) expect_patch(p + 1, 1'b1);
    end
    @(negedge clk);
    chk("scan4_done", 32'(done), 1);
    patch_ready = 1'b0;
    @(negedge clk);
    chk("scan4_done_clear", 32'(done), 0);
    chk("scan4_idle", 32'(busy), 0);
    chk("scan4_handshakes", hs - hs0, NP);
    chk("scan4_done_count", done_seen - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/patch_scan_ctrl.md
PATCH_SCAN_CTRL -- requirements
Module: patch_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Parameter ADDR_W, default 10, pixel address width; IMG_W*IMG_H SHALL be at most 2^ADDR_W.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a full-image 3x3 scan; sampled only in IDLE.
REQ-007 abort  in  1  synchronous abort of a scan in progress.
REQ-008 patch_ready  in  1  downstream accepts the current patch.
REQ-009 pixel_addr0..pixel_addr8  out  ADDR_W each  row-major 3x3 window addresses to the nine image memories.
REQ-010 load  out  1  capture strobe to the patch latch.
REQ-011 patch_valid  out  1  latched patch stable and presented downstream.
REQ-012 patch_row, patch_col  out  5 each  top-left coordinate of the current patch.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse after the last patch is accepted.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, LOAD, VALID and DONE.
REQ-016 Transitions SHALL be IDLE->ADDR on start; ADDR->LOAD unconditionally; LOAD->VALID unconditionally; VALID->ADDR on patch_ready when the patch is not last; VALID->DONE on patch_ready when the patch is last; DONE->IDLE unconditionally.
REQ-017 Memory read latency SHALL be 1 cycle: addresses are stable throughout ADDR, and the memory output is valid in LOAD.
REQ-018 load SHALL be 1 only in LOAD, so the latch captures at the LOAD->VALID edge.
REQ-019 patch_valid SHALL be 1 only in VALID and SHALL hold until patch_ready is sampled high.
REQ-020 Latency SHALL be 3 cycles from the edge that samples start to the first patch_valid, and 3 cycles from each accepting edge to the next patch_valid.
REQ-021 The block SHALL register a base equal to patch_row*IMG_W+patch_col.
REQ-022 pixel_addr[k] SHALL equal base + (k/3)*IMG_W + (k mod 3).
REQ-023 Addresses, patch_row and patch_col SHALL be registered and held constant from ADDR through VALID.
REQ-024 Advance on acceptance: if patch_col < IMG_W-3, patch_col += 1 and base += 1; otherwise patch_col = 0, patch_row += 1 and base += 3.
REQ-025 The last patch SHALL be the one with patch_row = IMG_H-3 and patch_col = IMG_W-3; with the defaults that is 676 patches, last base 725, last pixel_addr8 783.
REQ-026 On entering ADDR from IDLE, base, patch_row and patch_col SHALL be cleared to 0.
REQ-027 start while busy SHALL be ignored.
REQ-028 patch_ready outside VALID SHALL be ignored.
REQ-029 abort in any non-IDLE state SHALL force IDLE on the next edge without asserting done.
REQ-030 abort SHALL take priority over patch_ready and over the DONE transition.
REQ-031 All address arithmetic SHALL be unsigned and ADDR_W bits wide; no address SHALL exceed IMG_W*IMG_H-1.

Reset
REQ-032 On rst low, the FSM SHALL go to IDLE immediately.
REQ-033 On rst low, every output and internal counter SHALL clear to 0: all pixel_addr, load, patch_valid, patch_row, patch_col, busy, done and base.
REQ-034 A reset mid-scan SHALL discard progress; the next start SHALL begin again at patch (0,0).

Structure
REQ-035 State encoding, kernel size K=3 and the default IMG_W/IMG_H SHALL live in a shared package cnn_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the nine address adders are plain combinational logic feeding output registers.

Verification
REQ-037 Reset check: assert rst mid-VALID -> all outputs read 0 in the same cycle, and state is IDLE after release.
REQ-038 First patch: start pulse with patch_ready held 1 -> patch_valid 3 cycles later; pixel_addr0..8 = 0,1,2,28,29,30,56,57,58; load high exactly one cycle before patch_valid.
REQ-039 Row wrap: accept the patch at (0,25) -> next patch is (1,0) with base 28; pixel_addr0 = 28, pixel_addr8 = 86.
REQ-040 Full scan: patch_ready tied 1 -> exactly 676 patch_valid handshakes, last at (25,25) with pixel_addr8 = 783; done pulses once, then busy = 0.
REQ-041 Backpressure: hold patch_ready = 0 for 10 cycles in VALID -> patch_valid, addresses and coordinates remain stable, and load stays 0.
REQ-042 Abort and retrigger: abort during LOAD of patch 5 -> IDLE next cycle with no done; a start pulse during the aborted scan was ignored; a new start -> first patch (0,0).
